// File: rtl/div_defs.sv
// div_defs: shared definitions for the sequential divider.
// Provides the default operand width, FSM state encoding and the step-counter width helper.
package div_defs;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DZ} state_e;
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports: partial_in  {remainder, quotient-in-progress} before the step
//        divisor_mag divisor magnitude
//        partial_out partial remainder/quotient after shift and trial subtract
module div_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] partial_in,
  input  logic [W-1:0]   divisor_mag,
  output logic [2*W-1:0] partial_out
);
  logic [W:0]   hi;
  logic [W-1:0] diff;
  logic         borrow;
  // The shifted-up high half needs W+1 bits; once it is at least the divisor the
  // difference is below the divisor, so the low W bits of a modular subtract are exact.
  assign hi          = partial_in[2*W-1:W-1];
  assign borrow      = hi < {1'b0, divisor_mag};
  assign diff        = hi[W-1:0] - divisor_mag;
  assign partial_out = borrow ? {hi[W-1:0], partial_in[W-2:0], 1'b0}
                              : {diff, partial_in[W-2:0], 1'b1};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divide controller with signed fix-up and divide-by-zero.
// Ports: clock/clear    clock and synchronous active-high reset
//        start          request a divide (sampled only when idle)
//        is_signed      two's-complement operands when 1
//        dividend       A, sampled with start
//        divisor        B, sampled with start
//        busy           operation in progress
//        done           one-cycle pulse, result/div_zero valid
//        div_zero       last completed op had a zero divisor
//        result         {remainder, quotient}
module div_sequencer
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = count_width(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] part_q, part_d, step_out, result_q, result_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d, amag, bmag, quo, rem;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d, dz_q, dz_d;
  assign amag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign bmag = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  assign quo  = part_q[WIDTH-1:0];
  assign rem  = part_q[2*WIDTH-1:WIDTH];
  div_step #(.W(WIDTH)) u_step (
    .partial_in (part_q),
    .divisor_mag(bmag_q),
    .partial_out(step_out)
  );
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    part_d   = part_q;
    bmag_d   = bmag_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = |divisor ? S_ITER : S_DZ;
        count_d = '0;
        // A zero divisor keeps the raw dividend here so DZ can report it unchanged.
        part_d  = {{WIDTH{1'b0}}, |divisor ? amag : dividend};
        bmag_d  = bmag;
        qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        rneg_d  = is_signed & dividend[WIDTH-1];
      end
      S_ITER: begin
        part_d  = step_out;
        count_d = count_q + 1'b1;
        state_d = (count_q == CW'(WIDTH - 1)) ? S_FIX : S_ITER;
      end
      S_FIX: begin
        // Truncating division: quotient sign from both operands, remainder follows the dividend.
        result_d = {rneg_q ? -rem : rem, qneg_q ? -quo : quo};
        dz_d     = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        result_d = {part_q[WIDTH-1:0], {WIDTH{1'b1}}};
        dz_d     = 1'b1;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      part_q   <= '0;
      bmag_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      part_q   <= part_d;
      bmag_q   <= bmag_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign result   = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard-driven checks of the sequential divider.
module tb_div_sequencer;
  localparam int W = 32;
  logic           clock = 1'b0;
  logic           clear, start, is_signed;
  logic [W-1:0]   dividend, divisor;
  logic           busy, done, div_zero;
  logic [2*W-1:0] result;
  int             pass_cnt = 0;
  int             total_cnt = 0;
  logic [2*W:0]   sb[$];

  div_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .result   (result)
  );

  always #5 clock = ~clock;

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] ma, mb, q, r;
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[W-1] ^ b[W-1])) q = -q;
    if (s && a[W-1]) r = -r;
    return {1'b0, r, q};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    sb.push_back(model(a, b, s));
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int gaps);
    n    = 0;
    gaps = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) gaps++;
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    clear     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clock);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL reset div_zero: got %b want 0", div_zero); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL reset result: got %h want 0", result); else pass_cnt++;
    clear = 1'b0;
  endtask

  task automatic test_unsigned;
    int n, g;
    logic [2*W:0] e;
    launch(32'd100, 32'd7, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (n !== 33) $display("FAIL unsigned latency: got %0d edges want 33", n); else pass_cnt++;
    total_cnt++; if (g !== 0) $display("FAIL unsigned busy: low in %0d cycles want 0", g); else pass_cnt++;
    total_cnt++; if (result !== {32'd2, 32'd14}) $display("FAIL unsigned 100/7: got %h want %h", result, {32'd2, 32'd14}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL unsigned scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL unsigned busy at done: got %b want 0", busy); else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL done pulse width: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (result !== e[2*W-1:0]) $display("FAIL result hold: got %h want %h", result, e[2*W-1:0]); else pass_cnt++;
  endtask

  task automatic test_signed;
    int n, g;
    logic [2*W:0] e;
    launch(-32'd100, 32'd7, 1'b1);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (result !== {32'hFFFFFFFE, 32'hFFFFFFF2}) $display("FAIL signed -100/7: got %h want %h", result, {32'hFFFFFFFE, 32'hFFFFFFF2}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL signed -100/7 scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    launch(32'd100, -32'd7, 1'b1);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (result !== {32'd2, 32'hFFFFFFF2}) $display("FAIL signed 100/-7: got %h want %h", result, {32'd2, 32'hFFFFFFF2}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL signed 100/-7 scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    launch(-32'd100, -32'd7, 1'b1);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL signed -100/-7: got %h want %h", {div_zero, result}, e); else pass_cnt++;
  endtask

  task automatic test_div_zero;
    int n, g;
    logic [2*W:0] e;
    launch(32'h1234, 32'd0, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (n !== 1) $display("FAIL div_zero latency: got %0d edges want 1", n); else pass_cnt++;
    total_cnt++; if (div_zero !== 1'b1) $display("FAIL div_zero flag: got %b want 1", div_zero); else pass_cnt++;
    total_cnt++; if (result !== {32'h1234, 32'hFFFFFFFF}) $display("FAIL div_zero result: got %h want %h", result, {32'h1234, 32'hFFFFFFFF}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL div_zero scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    launch(32'd9, 32'd3, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (div_zero !== 1'b0) $display("FAIL div_zero clear: got %b want 0", div_zero); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL after div_zero scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
  endtask

  task automatic test_boundaries;
    int n, g;
    logic [2*W:0] e;
    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (result !== {32'd0, 32'h80000000}) $display("FAIL signed MIN/-1: got %h want %h", result, {32'd0, 32'h80000000}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL MIN/-1 scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (result !== {32'd0, 32'hFFFFFFFF}) $display("FAIL unsigned max/1: got %h want %h", result, {32'd0, 32'hFFFFFFFF}); else pass_cnt++;
    launch(32'hFFFFFFFF, 32'h80000000, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (result !== {32'h7FFFFFFF, 32'd1}) $display("FAIL unsigned max/2^31: got %h want %h", result, {32'h7FFFFFFF, 32'd1}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL max/2^31 scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
  endtask

  task automatic test_random;
    int n, g;
    logic [2*W:0] e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      launch(a, b, 1'($urandom_range(0, 1)));
      wait_done(n, g);
      e = sb.pop_front();
      total_cnt++; if (n >= 100) $display("FAIL random %0d timeout: got %0d edges want done", i, n); else pass_cnt++;
      total_cnt++; if ({div_zero, result} !== e) $display("FAIL random %0d: a=%h b=%h got %h want %h", i, a, b, {div_zero, result}, e); else pass_cnt++;
    end
  endtask

  task automatic test_clear_mid;
    int n, g;
    logic [2*W:0] e;
    launch(32'd100, 32'd7, 1'b0);
    e = sb.pop_back();
    repeat (10) @(posedge clock);
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL clear pre-check busy: got %b want 1", busy); else pass_cnt++;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL clear busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL clear done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL clear result: got %h want 0", result); else pass_cnt++;
    launch(32'd9, 32'd3, 1'b0);
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (n !== 33) $display("FAIL post-clear latency: got %0d edges want 33", n); else pass_cnt++;
    total_cnt++; if (result !== {32'd0, 32'd3}) $display("FAIL post-clear 9/3: got %h want %h", result, {32'd0, 32'd3}); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL post-clear scoreboard: got %h want %h", {div_zero, result}, e); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n, g;
    logic [2*W:0] e;
    sb.push_back(model(32'd100, 32'd7, 1'b0));
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clock);
    #1;
    // Junk operands with a zero divisor while busy: must not launch anything.
    dividend = 32'd5;
    divisor  = 32'd0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      start = ~start;
      @(posedge clock);
      #1;
      n++;
    end
    e = sb.pop_front();
    total_cnt++; if (n !== 33) $display("FAIL b2b first latency: got %0d edges want 33", n); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL b2b first result: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    sb.push_back(model(32'd50, 32'd5, 1'b0));
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b relaunch: got done=%b busy=%b want done=0 busy=1", done, busy); else pass_cnt++;
    wait_done(n, g);
    e = sb.pop_front();
    total_cnt++; if (n !== 33) $display("FAIL b2b second latency: got %0d edges want 33", n); else pass_cnt++;
    total_cnt++; if ({div_zero, result} !== e) $display("FAIL b2b second result: got %h want %h", {div_zero, result}, e); else pass_cnt++;
    @(posedge clock);
    #1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b no third op: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_boundaries;
    test_random;
    test_clear_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
